if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It owns the architectural PC register and drives instruction-memory read requests through a ready handshake. It presents the current PC and fetched instruction to the PC predictor and takes the predictor's nextPC back as the following fetch address. Fetched words go into the IF/ID pipeline register, which honours stall from the hazard unit and flush/redirect from the branch-resolution logic.

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 tb/tb_if_fetch_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port of the fetch stage.
// The fetch stage is the master: it issues mem_read/mem_addr.
// The memory is the slave: it answers with mem_data and mem_ready.
interface if_fetch_stage_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                 mem_read;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ready;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_data,
        output mem_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. It owns the PC and issues instruction-memory reads.
// It feeds pc/fetch_instr to the external predictor and loads the IF/ID register.
// FETCH waits for the memory. HOLD parks a word that arrived during a stall,
// so the word is neither dropped nor fetched twice.
module if_fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] next_pc,
    input  logic                 force_pc,
    input  logic [WORD_SIZE-1:0] force_pc_data,
    input  logic                 stall,
    if_fetch_stage_if.master     mem,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] fetch_instr,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_instr,
    output logic [WORD_SIZE-1:0] fetch_count
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t               state_q,       state_d;
    logic [WORD_SIZE-1:0] pc_q,          pc_d;
    logic [WORD_SIZE-1:0] hold_q,        hold_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic [WORD_SIZE-1:0] if_id_pc_q,    if_id_pc_d;
    logic [WORD_SIZE-1:0] if_id_instr_q, if_id_instr_d;
    logic [WORD_SIZE-1:0] fetch_count_q, fetch_count_d;

    // Memory request and the word offered to the predictor, decoded from the state.
    always_comb begin
        mem.mem_read = (state_q == S_FETCH);
        mem.mem_addr = pc_q;
        fetch_instr  = '0;
        if (state_q == S_HOLD) begin
            fetch_instr = hold_q;
        end else if (mem.mem_ready) begin
            fetch_instr = mem.mem_data;
        end
    end

    // Next-state logic. Priority: redirect, then stall, then normal progress.
    always_comb begin
        // NOTE: every *_d starts as its *_q. Each branch then assigns only what
        // changes, and no path can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        fetch_count_d = fetch_count_q;

        if (force_pc) begin
            // Squash the held word and any response that arrives this cycle.
            state_d       = S_FETCH;
            pc_d          = force_pc_data;
            hold_d        = '0;
            if_id_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem.mem_ready && !stall) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = mem.mem_data;
                        pc_d          = next_pc;
                        fetch_count_d = fetch_count_q + WORD_SIZE'(1);
                    end else if (mem.mem_ready && stall) begin
                        hold_d  = mem.mem_data;
                        state_d = S_HOLD;
                    end else if (!stall) begin
                        if_id_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = hold_q;
                        pc_d          = next_pc;
                        fetch_count_d = fetch_count_q + WORD_SIZE'(1);
                        state_d       = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: the hold buffer and the IF/ID payload are reset explicitly,
        // because fetch_instr and if_id_pc/if_id_instr are visible right after reset.
        // Sequential state uses non-blocking assignment only.
        if (!reset_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            hold_q        <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_q        <= hold_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage.
// A memory model with per-address latency and an in-bench predictor drive the DUT.
// A program-order reference model feeds a scoreboard that a separate monitor checks.
module tb_if_fetch_stage;

    localparam int          W        = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] next_pc;
    logic        force_pc;
    logic [15:0] force_pc_data;
    logic        stall;
    logic [15:0] pc, fetch_instr, if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid;

    int tests  = 0;
    int failed = 0;

    if_fetch_stage_if #(.WORD_SIZE(W)) mem_if ();

    if_fetch_stage #(.WORD_SIZE(W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .next_pc       (next_pc),
        .force_pc      (force_pc),
        .force_pc_data (force_pc_data),
        .stall         (stall),
        .mem           (mem_if),
        .pc            (pc),
        .fetch_instr   (fetch_instr),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Program image: the word stored at address a.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h6000;
    endfunction

    // Predictor: low nibble F means "skip ahead by bits [7:4]"; otherwise sequential.
    function automatic logic [15:0] pred(input logic [15:0] p, input logic [15:0] i);
        if (i[3:0] == 4'hF) return p + 16'd1 + {12'd0, i[7:4]};
        return p + 16'd1;
    endfunction

    assign next_pc = pred(pc, fetch_instr);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: latency restarts on an address change or when mem_read drops.
    // lat_mode < 0 picks a random latency of 0..3 per request.
    int          lat_mode = 0;
    int          lat_cur  = 0;
    int          lat_cnt  = 0;
    logic [15:0] last_addr = 16'h0;
    logic        last_read = 1'b0;

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_data  = 16'h0;
    end

    always @(negedge clk) begin
        if (mem_if.mem_read !== 1'b1) begin
            lat_cnt = 0;
            mem_if.mem_ready = 1'b0;
        end else begin
            if (mem_if.mem_addr !== last_addr || !last_read) begin
                lat_cnt = 0;
                lat_cur = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                lat_cnt++;
            end
            mem_if.mem_ready = (lat_cnt >= lat_cur);
        end
        mem_if.mem_data = mem_if.mem_ready ? mem_word(mem_if.mem_addr) : 16'($urandom);
        last_addr = mem_if.mem_addr;
        last_read = (mem_if.mem_read === 1'b1);
    end

    // Reference model, in program order.
    // m_pc is the next instruction address. m_held means a word was accepted during a stall.
    // exp_q holds the IF/ID entry expected on the next load.
    entry_t      exp_q[$];
    logic [15:0] m_pc, m_count, m_ifid_pc, m_ifid_instr, prev_count;
    logic        m_held, m_ifid_valid;
    logic        e_rst, e_force, e_stall, e_ready, load_exp, dut_load;
    logic [15:0] e_fdata;
    entry_t      got;

    always begin
        @(posedge clk);
        e_rst   = !reset_n;
        e_force = force_pc;
        e_fdata = force_pc_data;
        e_stall = stall;
        e_ready = mem_if.mem_ready;
        #1;
        if (e_rst) begin
            m_pc = RESET_PC; m_held = 1'b0; m_count = 16'h0;
            m_ifid_valid = 1'b0; m_ifid_pc = 16'h0; m_ifid_instr = 16'h0;
            exp_q.delete();
            exp_q.push_back('{pc: RESET_PC, instr: mem_word(RESET_PC)});
            prev_count = 16'h0;
            check("rst_pc", pc, RESET_PC);
            check("rst_valid", {15'd0, if_id_valid}, 16'd0);
            check("rst_ifid_pc", if_id_pc, 16'h0);
            check("rst_ifid_instr", if_id_instr, 16'h0);
            check("rst_count", fetch_count, 16'h0);
            check("rst_mem_read", {15'd0, mem_if.mem_read}, 16'd1);
            check("rst_mem_addr", mem_if.mem_addr, RESET_PC);
        end else begin
            load_exp = 1'b0;
            if (!e_force && !e_stall && (m_held || e_ready)) load_exp = 1'b1;

            // Scoreboard: pop whenever the DUT shows a new IF/ID load.
            dut_load = (fetch_count !== prev_count);
            check("load_event", {15'd0, dut_load}, {15'd0, load_exp});
            if (dut_load) begin
                if (exp_q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL sb_empty: load of pc %h with nothing expected", if_id_pc);
                end else begin
                    got = exp_q.pop_front();
                    check("sb_pc", if_id_pc, got.pc);
                    check("sb_instr", if_id_instr, got.instr);
                end
            end

            // Advance the reference model.
            if (e_force) begin
                m_pc = e_fdata; m_held = 1'b0; m_ifid_valid = 1'b0;
                exp_q.delete();
                exp_q.push_back('{pc: e_fdata, instr: mem_word(e_fdata)});
            end else if (e_stall) begin
                if (!m_held && e_ready) m_held = 1'b1;
            end else if (load_exp) begin
                m_ifid_valid = 1'b1; m_ifid_pc = m_pc; m_ifid_instr = mem_word(m_pc);
                m_count = m_count + 16'd1;
                m_pc = pred(m_pc, mem_word(m_pc));
                m_held = 1'b0;
                if (dut_load) exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                else begin
                    exp_q.delete();
                    exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                end
            end else begin
                m_ifid_valid = 1'b0;
            end

            check("pc", pc, m_pc);
            check("mem_addr", mem_if.mem_addr, m_pc);
            check("mem_read", {15'd0, mem_if.mem_read}, {15'd0, !m_held});
            check("ifid_valid", {15'd0, if_id_valid}, {15'd0, m_ifid_valid});
            check("ifid_pc", if_id_pc, m_ifid_pc);
            check("ifid_instr", if_id_instr, m_ifid_instr);
            check("fetch_count", fetch_count, m_count);
            if (m_held) check("held_instr", fetch_instr, mem_word(m_pc));
            prev_count = fetch_count;
        end
    end

    task automatic redirect(input logic [15:0] target);
        force_pc = 1'b1; force_pc_data = target;
        @(negedge clk);
        force_pc = 1'b0;
    endtask

    // Stimulus: directed scenarios first, then a randomized run.
    initial begin
        reset_n = 1'b0; force_pc = 1'b1; force_pc_data = 16'h1234; stall = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0; force_pc = 1'b0; stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait streaming.
        lat_mode = 0;
        repeat (6) @(negedge clk);

        // Two wait states per access.
        lat_mode = 2;
        repeat (12) @(negedge clk);

        // Stall capture at 0005 for three cycles.
        lat_mode = 0;
        redirect(16'h0005);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        repeat (3) @(negedge clk);

        // Redirect while parked in HOLD.
        stall = 1'b1;
        repeat (2) @(negedge clk);
        force_pc = 1'b1; force_pc_data = 16'h0040;
        @(negedge clk);
        force_pc = 1'b0; stall = 1'b0;
        repeat (4) @(negedge clk);

        // Ready at 0010 collides with a redirect to 0020.
        redirect(16'h0010);
        force_pc = 1'b1; force_pc_data = 16'h0020;
        @(negedge clk);
        force_pc = 1'b0;
        repeat (3) @(negedge clk);

        // PC wrap-around.
        redirect(16'hFFFE);
        repeat (5) @(negedge clk);

        // Randomized stall, redirect and latency.
        lat_mode = -1;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            force_pc = ($urandom_range(0, 19) == 0);
            force_pc_data = 16'($urandom);
            @(negedge clk);
        end
        force_pc = 1'b0; stall = 1'b0;
        repeat (10) @(negedge clk);

        check("sb_depth", 16'(exp_q.size()), 16'd1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
